// File: rtl/osc_pkg.sv
// osc_pkg: shared types and constants for the oscilloscope capture path
package osc_pkg;
   localparam int ADC_W = 10;
   localparam logic SLOPE_RISE = 1'b0;
   localparam logic SLOPE_FALL = 1'b1;
   typedef enum logic [2:0] {IDLE, PRETRIG, WAIT_TRIG, POST, DONE} cap_state_t;
endpackage

// File: rtl/trigger_capture_if.sv
// trigger_capture_if: ADC sample, trigger control and record readout bundle
interface trigger_capture_if #(
   parameter int DATA_W = osc_pkg::ADC_W,
   parameter int DEPTH  = 256,
   parameter int ADDR_W = $clog2(DEPTH)
);
   logic              data_ready;
   logic [DATA_W-1:0] data;
   logic              arm;
   logic              force_trig;
   logic [DATA_W-1:0] trig_level;
   logic              trig_slope;
   logic [ADDR_W-1:0] pretrig;
   logic [ADDR_W-1:0] rd_addr;
   logic [DATA_W-1:0] rd_data;
   logic              armed;
   logic              triggered;
   logic              done;
   modport master (
      output data_ready, data, arm, force_trig, trig_level, trig_slope, pretrig, rd_addr,
      input  rd_data, armed, triggered, done
   );
   modport slave (
      input  data_ready, data, arm, force_trig, trig_level, trig_slope, pretrig, rd_addr,
      output rd_data, armed, triggered, done
   );
endinterface

// File: rtl/capture_ram.sv
// capture_ram: simple dual-port RAM, one write port and one registered read port
module capture_ram #(
   parameter int DATA_W = 10,
   parameter int DEPTH  = 256,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk_i,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);
   logic [DATA_W-1:0] mem [DEPTH];
   always_ff @(posedge clk_i) begin
      if (we) mem[waddr] <= wdata;
      rdata <= mem[raddr];
   end
endmodule

// File: rtl/trigger_capture.sv
// trigger_capture: armed edge trigger with pre-trigger depth over a circular sample record
module trigger_capture
   import osc_pkg::*;
#(
   parameter int DATA_W = ADC_W,
   parameter int DEPTH  = 256,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input logic clk_i,
   input logic rst_i,
   trigger_capture_if.slave bus
);
   cap_state_t state, state_nxt;
   logic ready_q, stb, wr_en, hit, force_q, prev_valid, armed;
   logic [ADDR_W-1:0] wr_ptr, start_ptr, cnt, cnt_nxt, pre_n, post_n;
   logic [DATA_W-1:0] prev, ram_q;
   assign armed   = state inside {PRETRIG, WAIT_TRIG, POST};
   assign stb     = bus.data_ready & ~ready_q;
   assign wr_en   = stb & armed & ~bus.arm;
   assign cnt_nxt = cnt + 1'b1;
   assign post_n  = ADDR_W'(DEPTH - 1) - pre_n;
   // a pending or coincident force wins; otherwise a real crossing needs a stored predecessor
   assign hit = force_q | bus.force_trig | (prev_valid & (bus.trig_slope == SLOPE_RISE
      ? (prev < bus.trig_level && bus.data >= bus.trig_level)
      : (prev > bus.trig_level && bus.data <= bus.trig_level)));
   always_ff @(posedge clk_i) begin
      if (rst_i) state <= IDLE;
      else state <= state_nxt;
   end
   always_comb begin
      state_nxt = state;
      if (bus.arm) state_nxt = (bus.pretrig == '0) ? WAIT_TRIG : PRETRIG;
      else if (wr_en) begin
         case (state)
            PRETRIG:   if (cnt_nxt == pre_n) state_nxt = WAIT_TRIG;
            WAIT_TRIG: if (hit) state_nxt = (post_n == '0) ? DONE : POST;
            POST:      if (cnt_nxt == post_n) state_nxt = DONE;
            default:   state_nxt = state;
         endcase
      end
   end
   always_comb begin
      bus.armed     = armed;
      bus.triggered = state inside {POST, DONE};
      bus.done      = state == DONE;
      bus.rd_data   = (state == DONE) ? ram_q : '0;
   end
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ready_q    <= 1'b1;
         wr_ptr     <= '0;
         start_ptr  <= '0;
         cnt        <= '0;
         pre_n      <= '0;
         prev       <= '0;
         prev_valid <= 1'b0;
         force_q    <= 1'b0;
      end else begin
         ready_q <= bus.data_ready;
         if (bus.arm) begin
            pre_n      <= bus.pretrig;
            cnt        <= '0;
            prev_valid <= 1'b0;
            force_q    <= 1'b0;
         end else begin
            if (state == WAIT_TRIG && bus.force_trig) force_q <= 1'b1;
            if (wr_en) begin
               wr_ptr     <= wr_ptr + 1'b1;
               prev       <= bus.data;
               prev_valid <= 1'b1;
               cnt        <= (state == WAIT_TRIG) ? '0 : cnt_nxt;
            end
            if (wr_en && state == WAIT_TRIG && hit) begin
               start_ptr <= wr_ptr - pre_n;
               force_q   <= 1'b0;
            end
         end
      end
   end
   capture_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_ram (
      .clk_i (clk_i),
      .we    (wr_en),
      .waddr (wr_ptr),
      .wdata (bus.data),
      .raddr (start_ptr + bus.rd_addr),
      .rdata (ram_q)
   );
endmodule

// File: tb/tb_trigger_capture.sv
// tb_trigger_capture: table and model driven check of capture, trigger timing and readout
module tb_trigger_capture;
   import osc_pkg::*;
   typedef struct {int addr; logic [9:0] exp;} vec_t;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int n_vec = 0;
   int n_err = 0;
   logic [9:0] src [600];
   logic [9:0] exp_q [$];
   vec_t tbl [6];
   trigger_capture_if bus ();
   trigger_capture dut (.clk_i(clk), .rst_i(rst), .bus(bus));
   always #5 clk = ~clk;
   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish, required completion");
      $fatal(1);
   end
   task automatic check(input string name, input int got, input int exp);
      n_vec++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, required %0d", name, got, exp);
      end
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   // index of the first stored sample that should trigger, judged on the fed sequence
   function automatic int model_trig(input int pre, input logic [9:0] lvl, input logic slope, input int force_at);
      for (int i = pre; i < 600; i++) begin
         if (i == force_at) return i;
         if (i >= 1 && (slope == SLOPE_RISE ? (src[i-1] < lvl && src[i] >= lvl)
                                            : (src[i-1] > lvl && src[i] <= lvl))) return i;
      end
      return -1;
   endfunction
   task automatic feed(input int i, input int ti, input int total, input int hold);
      bus.data = src[i];
      bus.data_ready = 1'b1;
      repeat (hold) step();
      bus.data_ready = 1'b0;
      if (i == ti - 1) check("trig_early", int'(bus.triggered), 0);
      if (i == ti) check("trig_rise", int'(bus.triggered), 1);
      if (i == total - 2) check("done_early", int'(bus.done), 0);
      if (i == total - 1) begin
         check("done_rise", int'(bus.done), 1);
         check("armed_fall", int'(bus.armed), 0);
      end
      step();
   endtask
   task automatic read_addr(input int a, input logic [9:0] exp);
      bus.rd_addr = a[7:0];
      exp_q.push_back(exp);
      step();
      check($sformatf("rd_addr_%0d", a), int'(bus.rd_data), int'(exp_q.pop_front()));
   endtask
   task automatic run_capture(input int pre, input int lvl, input logic slope, input int force_at,
                              input int hold_at, input int stop_at, input bit use_tbl);
      int ti, total, last;
      int addrs [4];
      ti = model_trig(pre, 10'(lvl), slope, force_at);
      total = ti + 256 - pre;
      last = (stop_at >= 0) ? stop_at : total;
      bus.pretrig = 8'(pre);
      bus.trig_level = 10'(lvl);
      bus.trig_slope = slope;
      bus.arm = 1'b1;
      step();
      bus.arm = 1'b0;
      check("armed_at_arm", int'(bus.armed), 1);
      check("trig_clear_at_arm", int'(bus.triggered), 0);
      check("done_clear_at_arm", int'(bus.done), 0);
      for (int i = 0; i < last; i++) begin
         if (i == force_at) begin
            bus.force_trig = 1'b1;
            step();
            bus.force_trig = 1'b0;
         end
         feed(i, ti, total, (i == hold_at) ? 5 : 1);
      end
      if (stop_at < 0) begin
         if (use_tbl) begin
            foreach (tbl[k]) read_addr(tbl[k].addr, tbl[k].exp);
         end else begin
            addrs = '{0, pre, 255, 128};
            foreach (addrs[k]) read_addr(addrs[k], src[ti - pre + addrs[k]]);
         end
      end
   endtask
   initial begin
      bus.data_ready = 1'b0;
      bus.data = '0;
      bus.arm = 1'b0;
      bus.force_trig = 1'b0;
      bus.trig_level = '0;
      bus.trig_slope = SLOPE_RISE;
      bus.pretrig = '0;
      bus.rd_addr = '0;
      tbl = '{'{0, 10'd84}, '{16, 10'd100}, '{255, 10'd339}, '{15, 10'd99}, '{17, 10'd101}, '{128, 10'd212}};
      repeat (3) step();
      check("rst_armed", int'(bus.armed), 0);
      check("rst_triggered", int'(bus.triggered), 0);
      check("rst_done", int'(bus.done), 0);
      check("rst_rd_data", int'(bus.rd_data), 0);
      rst = 1'b0;
      step();
      foreach (src[i]) src[i] = 10'(i);
      run_capture(16, 100, SLOPE_RISE, -1, -1, -1, 1'b1);
      foreach (src[i]) src[i] = 10'd400;
      src[0] = 10'd600; src[1] = 10'd550; src[2] = 10'd500;
      run_capture(1, 500, SLOPE_FALL, -1, -1, -1, 1'b0);
      foreach (src[i]) src[i] = 10'(i);
      run_capture(0, 5, SLOPE_RISE, -1, 3, -1, 1'b0);
      run_capture(255, 300, SLOPE_RISE, -1, -1, -1, 1'b0);
      foreach (src[i]) src[i] = 10'(200 + i % 8);
      run_capture(4, 900, SLOPE_RISE, 6, -1, -1, 1'b0);
      foreach (src[i]) src[i] = 10'(i);
      run_capture(16, 100, SLOPE_RISE, -1, -1, 110, 1'b0);
      foreach (src[i]) src[i] = 10'(i + 7);
      run_capture(16, 100, SLOPE_RISE, -1, -1, -1, 1'b0);
      foreach (src[i]) src[i] = 10'd10;
      run_capture(0, 900, SLOPE_RISE, -1, -1, 3, 1'b0);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("midrst_armed", int'(bus.armed), 0);
      check("midrst_triggered", int'(bus.triggered), 0);
      check("midrst_done", int'(bus.done), 0);
      check("midrst_rd_data", int'(bus.rd_data), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
